// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: downstream control (stall/flush/branch), the ROM
// address/data pair and the IF/ID register outputs.
//   master : the fetch unit (drives ROM address and IF/ID outputs)
//   slave  : the surrounding pipeline and instruction ROM
interface fetch_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             stall_i;
    logic             flush_i;
    logic             branch_i;
    logic [31:0]      branch_target_i;
    logic [31:0]      imem_addr_o;
    logic [31:0]      imem_rd_i;
    logic [31:0]      instr_d_o;
    logic [31:0]      pc_d_o;
    logic [31:0]      pc_plus8_d_o;
    logic             valid_d_o;
    logic             halted_o;
    logic [CNT_W-1:0] fetch_count_o;

    modport master (
        input  stall_i, flush_i, branch_i, branch_target_i, imem_rd_i,
        output imem_addr_o, instr_d_o, pc_d_o, pc_plus8_d_o, valid_d_o, halted_o,
               fetch_count_o
    );

    modport slave (
        output stall_i, flush_i, branch_i, branch_target_i, imem_rd_i,
        input  imem_addr_o, instr_d_o, pc_d_o, pc_plus8_d_o, valid_d_o, halted_o,
               fetch_count_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, presents it to a combinational ROM and
// captures the returned word into the IF/ID register with PC and PC+8.
// Stops fetching on HALT_WORD or an out-of-range fetch; only a branch or reset
// restarts it.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : fetch_unit_if master (control in, ROM address/data, IF/ID out)
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 64,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pcd_q, pcd_d;
    logic [31:0]      pc8_q, pc8_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_halt;
    logic             advance;

    assign hit_halt = (bus.imem_rd_i == HALT_WORD) || (pc_q[31:2] >= 30'(ROM_WORDS));
    // Flush beats stall, but a stalled flush still holds the PC.
    assign advance  = (state_q == StRun) && !bus.stall_i;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.branch_i) begin
            state_d = StRun;
        end else if (advance && hit_halt) begin
            state_d = StHalt;
        end
    end

    // Datapath next-state: PC, IF/ID and counter
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (bus.branch_i) begin
            pc_d    = bus.branch_target_i & ~32'h3;
            instr_d = '0;
            valid_d = 1'b0;
        end else if (state_q == StRun) begin
            if (bus.flush_i) begin
                instr_d = '0;
                valid_d = 1'b0;
                if (advance && !hit_halt) begin
                    pc_d = pc_q + 32'd4;
                end
            end else if (advance) begin
                if (hit_halt) begin
                    // Halt word is never issued; PC stays on it.
                    instr_d = '0;
                    valid_d = 1'b0;
                end else begin
                    pc_d    = pc_q + 32'd4;
                    instr_d = bus.imem_rd_i;
                    pcd_d   = pc_q;
                    pc8_d   = pc_q + 32'd8;
                    valid_d = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pcd_q   <= '0;
            pc8_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pc8_q   <= pc8_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs
    always_comb begin
        bus.imem_addr_o   = pc_q;
        bus.instr_d_o     = instr_q;
        bus.pc_d_o        = pcd_q;
        bus.pc_plus8_d_o  = pc8_q;
        bus.valid_d_o     = valid_q;
        bus.halted_o      = (state_q == StHalt);
        bus.fetch_count_o = cnt_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed walk through the main scenarios
// followed by randomized control/ROM stimulus against a behavioural model.
module tb_fetch_unit;

    localparam int unsigned ROM_WORDS = 64;
    localparam int unsigned CNT_W     = 16;
    localparam logic [31:0] OOR_WORD  = 32'hFFFF_FFFF;

    logic clk;
    logic reset;

    fetch_unit_if #(.CNT_W(CNT_W)) bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ROM_WORDS(ROM_WORDS),
        .HALT_WORD(32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] rom [ROM_WORDS];

    // Combinational ROM
    always_comb begin
        if (bus.imem_addr_o < 32'(ROM_WORDS * 4)) begin
            bus.imem_rd_i = rom[bus.imem_addr_o[7:2]];
        end else begin
            bus.imem_rd_i = OOR_WORD;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0]      m_pc, m_instr, m_pcd, m_pc8;
    logic             m_valid, m_halted;
    logic [CNT_W-1:0] m_cnt;

    task automatic model_edge(input logic rst, input logic st, input logic fl, input logic br,
                              input logic [31:0] tgt);
        logic [31:0] word;
        logic        stop;
        word = (m_pc < 32'(ROM_WORDS * 4)) ? rom[m_pc[7:2]] : OOR_WORD;
        stop = (word == 32'h0) || (m_pc >= 32'(ROM_WORDS * 4));
        if (!rst) begin
            m_pc = 0; m_instr = 0; m_pcd = 0; m_pc8 = 0;
            m_valid = 0; m_halted = 0; m_cnt = 0;
        end else if (br) begin
            m_pc = {tgt[31:2], 2'b00};
            m_valid = 0; m_instr = 0; m_halted = 0;
        end else if (m_halted) begin
            // frozen until branch or reset
        end else if (fl) begin
            m_valid = 0; m_instr = 0;
            if (!st) begin
                if (stop) m_halted = 1;
                else m_pc = m_pc + 4;
            end
        end else if (st) begin
            // hold
        end else if (stop) begin
            m_halted = 1; m_valid = 0; m_instr = 0;
        end else begin
            m_instr = word; m_pcd = m_pc; m_pc8 = m_pc + 8; m_valid = 1;
            m_pc = m_pc + 4;
            if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_all();
        check("addr",   bus.imem_addr_o,   m_pc);
        check("instr",  bus.instr_d_o,     m_instr);
        check("pc_d",   bus.pc_d_o,        m_pcd);
        check("pc8",    bus.pc_plus8_d_o,  m_pc8);
        check("valid",  32'(bus.valid_d_o), 32'(m_valid));
        check("halted", 32'(bus.halted_o),  32'(m_halted));
        check("count",  32'(bus.fetch_count_o), 32'(m_cnt));
    endtask

    // Apply inputs for one edge, advance the model, then sample after the edge.
    task automatic step(input logic rst, input logic st, input logic fl, input logic br,
                        input logic [31:0] tgt);
        reset               = rst;
        bus.stall_i         = st;
        bus.flush_i         = fl;
        bus.branch_i        = br;
        bus.branch_target_i = tgt;
        model_edge(rst, st, fl, br, tgt);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.branch_i = 1'b0;
        bus.branch_target_i = '0;
        m_pc = 0; m_instr = 0; m_pcd = 0; m_pc8 = 0;
        m_valid = 0; m_halted = 0; m_cnt = 0;

        for (int i = 0; i < ROM_WORDS; i++) rom[i] = 32'hE000_0000 | 32'(i + 1);
        rom[0]  = 32'hE3A0204B;
        rom[1]  = 32'hE04F000F;
        rom[2]  = 32'h11111111;
        rom[3]  = 32'hE3A04055;
        rom[4]  = 32'hE2811001;
        rom[5]  = 32'h0000_0000;
        rom[19] = 32'hE1A0_0013;

        // Reset
        step(0, 0, 0, 0, 0);
        check("rst_addr", bus.imem_addr_o, 32'h0);
        check("rst_cnt", 32'(bus.fetch_count_o), 32'h0);

        // Straight-line fetch
        step(1, 0, 0, 0, 0);
        check("sl_addr1", bus.imem_addr_o, 32'h4);
        check("sl_instr", bus.instr_d_o, 32'hE3A0204B);
        check("sl_pcd", bus.pc_d_o, 32'h0);
        check("sl_pc8", bus.pc_plus8_d_o, 32'h8);
        check("sl_valid", 32'(bus.valid_d_o), 32'h1);
        step(1, 0, 0, 0, 0);
        check("sl_addr2", bus.imem_addr_o, 32'h8);

        // Stall for three cycles at PC=8
        repeat (3) step(1, 1, 0, 0, 0);
        check("stall_addr", bus.imem_addr_o, 32'h8);
        check("stall_instr", bus.instr_d_o, 32'hE04F000F);
        check("stall_cnt", 32'(bus.fetch_count_o), 32'h2);
        step(1, 0, 0, 0, 0);
        check("resume_instr", bus.instr_d_o, 32'h11111111);
        check("resume_pcd", bus.pc_d_o, 32'h8);
        step(1, 0, 0, 0, 0);
        check("sl_cnt4", 32'(bus.fetch_count_o), 32'h4);
        step(1, 0, 0, 0, 0);

        // Halt on ROM[5]==0
        step(1, 0, 0, 0, 0);
        check("halt_flag", 32'(bus.halted_o), 32'h1);
        check("halt_addr", bus.imem_addr_o, 32'h14);
        check("halt_cnt", 32'(bus.fetch_count_o), 32'h5);
        step(1, 1, 1, 0, 0);
        check("halt_hold", 32'(bus.halted_o), 32'h1);
        step(1, 0, 0, 1, 32'h0);
        check("unhalt", 32'(bus.halted_o), 32'h0);
        step(1, 0, 0, 0, 0);
        check("refetch0", bus.instr_d_o, 32'hE3A0204B);

        // Branch during stall, misaligned target
        step(1, 1, 0, 1, 32'h0000_004E);
        check("br_addr", bus.imem_addr_o, 32'h4C);
        check("br_valid", 32'(bus.valid_d_o), 32'h0);
        step(1, 0, 0, 0, 0);
        check("br_instr", bus.instr_d_o, 32'hE1A0_0013);
        check("br_pcd", bus.pc_d_o, 32'h4C);

        // Out-of-range fetch
        step(1, 0, 0, 1, 32'h0000_0100);
        step(1, 0, 0, 0, 0);
        check("oor_halt", 32'(bus.halted_o), 32'h1);
        check("oor_valid", 32'(bus.valid_d_o), 32'h0);

        // Reset mid-run at PC=0x20
        step(1, 0, 0, 1, 32'h18);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("mid_addr", bus.imem_addr_o, 32'h20);
        check("mid_valid", 32'(bus.valid_d_o), 32'h1);
        step(0, 0, 0, 0, 0);
        check("mrst_addr", bus.imem_addr_o, 32'h0);
        check("mrst_instr", bus.instr_d_o, 32'h0);
        check("mrst_pc8", bus.pc_plus8_d_o, 32'h0);
        check("mrst_cnt", 32'(bus.fetch_count_o), 32'h0);

        // Randomized phase
        for (int i = 0; i < ROM_WORDS; i++) begin
            rom[i] = ($urandom_range(0, 19) == 0) ? 32'h0 : ($urandom() | 32'h1);
        end
        step(0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_st, r_fl, r_br;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 199) != 0);
            r_st  = ($urandom_range(0, 4) == 0);
            r_fl  = ($urandom_range(0, 9) == 0);
            r_br  = ($urandom_range(0, 9) == 0);
            r_tgt = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 280));
            step(r_rst, r_st, r_fl, r_br, r_tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
